// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory responder: access encodings, FSM states,
// the latched request payload and the lane/legality helpers.
package data_mem_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Request fields captured on the accepting edge.
  typedef struct packed {
    logic            wr;
    logic [2:0]      f3;
    logic [1:0]      lane;
    logic [XLEN-1:0] wdata;
    logic            err;
  } dmem_req_t;

  // Conflicting strobes, unsupported size for the direction, or misalignment.
  function automatic logic access_illegal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (wr) begin
      bad = !(f3 inside {F3_B, F3_H, F3_W});
    end else begin
      bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    if ((f3 == F3_H || f3 == F3_HU) && lane[0]) begin
      bad = 1'b1;
    end
    if (f3 == F3_W && lane != 2'b00) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = BE_W'(4'b0001 << lane);
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across all lanes; byte enables pick the live ones.
  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [XLEN-1:0] word);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = word >> {lane, 3'b000};
    case (f3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   res = {24'd0, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   res = {16'd0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [XLEN-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store responder: accepts core strobes, services them against dmem_ram after a
// fixed number of wait states, stalls the core meanwhile and returns extended load data.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            done,
  output logic            err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] widx_q;
  dmem_req_t         req_q;
  logic [XLEN-1:0]   hold_q;
  logic [XLEN-1:0]   resp_data;

  logic              req_valid;
  logic              req_bad;
  logic              latch;

  logic              ram_en;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [XLEN-1:0]   ram_wdata;
  logic [XLEN-1:0]   ram_rdata;

  // Upper address bits are ignored so accesses wrap modulo the RAM size.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^addr[XLEN-1:ADDR_W+2];

  assign req_valid = mem_rd | mem_wr;
  assign req_bad   = access_illegal(mem_rd, mem_wr, funct3, addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    latch     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = req_q.wr;
    ram_be    = store_be(req_q.f3, req_q.lane);
    ram_addr  = widx_q;
    ram_wdata = store_lanes(req_q.f3, req_q.wdata);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          stall = 1'b1;
          latch = 1'b1;
          if (req_bad) begin
            state_d = ST_RESP;
          end else if (WAIT_CYCLES == 0) begin
            // No wait states: the accepting edge is also the access edge.
            state_d   = ST_RESP;
            ram_en    = 1'b1;
            ram_we    = mem_wr;
            ram_be    = store_be(funct3, addr[1:0]);
            ram_addr  = addr[ADDR_W+1:2];
            ram_wdata = store_lanes(funct3, wdata);
          end else begin
            state_d = ST_BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          ram_en  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx_q <= '0;
      req_q  <= '0;
    end else if (latch) begin
      widx_q <= addr[ADDR_W+1:2];
      req_q  <= '{wr: mem_wr, f3: funct3, lane: addr[1:0], wdata: wdata, err: req_bad};
    end
  end

  // Stores and rejected accesses report zero data.
  always_comb begin
    resp_data = '0;
    if (!req_q.err && !req_q.wr) begin
      resp_data = load_extend(req_q.f3, req_q.lane, ram_rdata);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (state_q == ST_RESP) begin
      hold_q <= resp_data;
    end
  end

  assign done  = (state_q == ST_RESP);
  assign err   = done && req_q.err;
  assign rdata = done ? resp_data : hold_q;

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (2 and 0 wait states) checked every cycle
// against a byte-level memory model plus hand-computed literal results.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int unsigned AW = 10;
  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst_n  [NI];
  logic        mem_rd [NI];
  logic        mem_wr [NI];
  logic [2:0]  funct3 [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic [31:0] rdata  [NI];
  logic        stall  [NI];
  logic        done   [NI];
  logic        err    [NI];

  logic [31:0] mdl [NI][1 << AW];
  logic        exp_stall [NI];
  logic        exp_done  [NI];
  logic        exp_err   [NI];
  logic [31:0] exp_rdata [NI];
  logic        exp_known [NI];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
    .funct3(funct3[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .stall(stall[0]), .done(done[0]), .err(err[0])
  );

  data_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
    .funct3(funct3[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .stall(stall[1]), .done(done[1]), .err(err[1])
  );

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic illegal_m(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    logic legal_size;
    if (rd && wr) return 1'b1;
    if (wr) legal_size = (f3 inside {3'd0, 3'd1, 3'd2});
    else    legal_size = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal_size) return 1'b1;
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic void store_m(input int i, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd);
    int w;
    int ln;
    w  = int'(a[AW+1:2]);
    ln = int'(a[1:0]);
    for (int b = 0; b < size_of(f3); b++) begin
      mdl[i][w][8*(ln+b) +: 8] = wd[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] load_m(input int i, input logic [2:0] f3, input logic [31:0] a);
    int w;
    int ln;
    int sz;
    logic [31:0] v;
    w  = int'(a[AW+1:2]);
    ln = int'(a[1:0]);
    sz = size_of(f3);
    v  = '0;
    for (int b = 0; b < sz; b++) begin
      v[8*b +: 8] = mdl[i][w][8*(ln+b) +: 8];
    end
    if (sz < 4 && !f3[2] && v[8*sz-1]) begin
      v = v | ~((32'd1 << (8*sz)) - 32'd1);
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model expectations.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("stall[%0d]", i), 32'(stall[i]), 32'(exp_stall[i]));
      chk($sformatf("done[%0d]", i),  32'(done[i]),  32'(exp_done[i]));
      chk($sformatf("err[%0d]", i),   32'(err[i]),   32'(exp_err[i]));
      if (exp_known[i]) chk($sformatf("rdata[%0d]", i), rdata[i], exp_rdata[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_stall[i] = 1'b0;
      exp_done[i]  = 1'b0;
      exp_err[i]   = 1'b0;
    end
  endtask

  task automatic access(input int i, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got, output logic got_err,
                        output int n_stall, output int lat);
    logic bad;
    int nb;
    bad = illegal_m(rd, wr, f3, a);
    nb = bad ? 0 : wait_of(i);
    n_stall = 0;
    lat = -1;
    got = '0;
    got_err = 1'b0;
    for (int c = 0; c <= nb + 1; c++) begin
      step();
      if (c == 0) begin
        mem_rd[i] = rd; mem_wr[i] = wr; funct3[i] = f3; addr[i] = a; wdata[i] = wd;
      end
      if (c <= nb) begin
        exp_stall[i] = 1'b1;
      end else begin
        mem_rd[i] = 1'b0;
        mem_wr[i] = 1'b0;
        exp_done[i] = 1'b1;
        exp_err[i]  = bad;
        if (bad) begin
          exp_rdata[i] = '0;
          exp_known[i] = 1'b1;
        end else if (wr) begin
          store_m(i, f3, a, wd);
          exp_known[i] = 1'b0;
        end else begin
          exp_rdata[i] = load_m(i, f3, a);
          exp_known[i] = 1'b1;
        end
      end
      #3;
      if (stall[i]) n_stall++;
      if (done[i] && lat < 0) lat = c;
      if (done[i]) begin
        got = rdata[i];
        got_err = err[i];
      end
    end
  endtask

  task automatic do_st(input int i, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string nm);
    logic [31:0] g; logic e; int ns; int lat;
    access(i, 1'b0, 1'b1, f3, a, wd, g, e, ns, lat);
    chk({nm, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic do_ld(input int i, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] want, input string nm);
    logic [31:0] g; logic e; int ns; int lat;
    access(i, 1'b1, 1'b0, f3, a, 32'd0, g, e, ns, lat);
    chk(nm, g, want);
    chk({nm, "_err"}, 32'(e), 32'd0);
  endtask

  task automatic do_bad(input int i, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input string nm);
    logic [31:0] g; logic e; int ns; int lat;
    access(i, rd, wr, f3, a, wd, g, e, ns, lat);
    chk({nm, "_err"}, 32'(e), 32'd1);
    chk({nm, "_rdata"}, g, 32'd0);
    chk({nm, "_lat"}, 32'(lat), 32'd1);
  endtask

  initial begin
    logic [31:0] g;
    logic e;
    int ns;
    int lat;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b1; mem_rd[i] = 1'b0; mem_wr[i] = 1'b0;
      funct3[i] = 3'd0; addr[i] = '0; wdata[i] = '0;
      exp_stall[i] = 1'b0; exp_done[i] = 1'b0; exp_err[i] = 1'b0;
      exp_rdata[i] = '0; exp_known[i] = 1'b1;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #2;
    chk("reset_rdata", rdata[0], 32'd0);
    chk("reset_stall", 32'(stall[0]), 32'd0);
    chk("reset_done",  32'(done[0]), 32'd0);
    chk("reset_err",   32'(err[1]), 32'd0);
    step();
    step();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();

    // Word store/load with two wait states.
    access(0, 1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, g, e, ns, lat);
    chk("sw_stall_cycles", 32'(ns), 32'd3);
    chk("sw_done_lat", 32'(lat), 32'd3);
    access(0, 1'b1, 1'b0, F3_W, 32'h10, 32'd0, g, e, ns, lat);
    chk("lw_data", g, 32'hDEADBEEF);
    chk("lw_err", 32'(e), 32'd0);
    chk("lw_stall_cycles", 32'(ns), 32'd3);
    chk("lw_done_lat", 32'(lat), 32'd3);

    // Byte lanes and extension.
    do_st(0, F3_W, 32'h4, 32'h0, "sw_zero4");
    do_st(0, F3_B, 32'h5, 32'h000000F0, "sb_5");
    do_ld(0, F3_W,  32'h4, 32'h0000F000, "lw_4");
    do_ld(0, F3_B,  32'h5, 32'hFFFFFFF0, "lb_5");
    do_ld(0, F3_BU, 32'h5, 32'h000000F0, "lbu_5");

    // Halfword lanes and extension.
    do_st(0, F3_W, 32'h20, 32'h0, "sw_zero20");
    do_st(0, F3_H, 32'h22, 32'h00008001, "sh_22");
    do_ld(0, F3_H,  32'h22, 32'hFFFF8001, "lh_22");
    do_ld(0, F3_HU, 32'h22, 32'h00008001, "lhu_22");
    do_ld(0, F3_W,  32'h20, 32'h80010000, "lw_20");

    // Misaligned and conflicting accesses leave memory untouched.
    do_st(0, F3_W, 32'h0, 32'hA5A5A5A5, "sw_0");
    do_bad(0, 1'b1, 1'b0, F3_W, 32'h6, 32'd0, "lw_misalign");
    do_bad(0, 1'b0, 1'b1, F3_H, 32'h3, 32'h1234, "sh_misalign");
    do_bad(0, 1'b1, 1'b0, 3'b011, 32'h0, 32'd0, "ld_bad_f3");
    do_bad(0, 1'b0, 1'b1, F3_BU, 32'h0, 32'hFF, "st_bad_f3");
    do_ld(0, F3_W, 32'h0, 32'hA5A5A5A5, "lw_0_after_bad");
    do_ld(0, F3_W, 32'h4, 32'h0000F000, "lw_4_after_bad");
    do_bad(0, 1'b1, 1'b1, F3_W, 32'h10, 32'h0, "rd_wr_both");

    // Zero wait states and address aliasing.
    access(1, 1'b0, 1'b1, F3_W, 32'h10, 32'h13579BDF, g, e, ns, lat);
    chk("w0_sw_stall_cycles", 32'(ns), 32'd1);
    access(1, 1'b1, 1'b0, F3_W, 32'h10, 32'd0, g, e, ns, lat);
    chk("w0_lw_data", g, 32'h13579BDF);
    chk("w0_lw_stall_cycles", 32'(ns), 32'd1);
    chk("w0_lw_done_lat", 32'(lat), 32'd1);
    do_ld(1, F3_W, 32'h10 + 32'(4 * (1 << AW)), 32'h13579BDF, "w0_lw_alias");
    do_st(1, F3_B, 32'h1013, 32'h0000007F, "w0_sb_alias");
    do_ld(1, F3_B, 32'h13, 32'h0000007F, "w0_lb_13");
    do_ld(1, F3_H, 32'h12, 32'h00007F57, "w0_lh_12");

    // Store aborted by reset while still waiting.
    do_st(0, F3_W, 32'h8, 32'h11223344, "sw_8_pre");
    do_ld(0, F3_W, 32'h8, 32'h11223344, "lw_8_pre");
    step();
    mem_wr[0] = 1'b1; funct3[0] = F3_W; addr[0] = 32'h8; wdata[0] = 32'h55AA55AA;
    exp_stall[0] = 1'b1;
    step();
    rst_n[0] = 1'b0;
    mem_wr[0] = 1'b0;
    exp_rdata[0] = '0;
    exp_known[0] = 1'b1;
    #1;
    chk("abort_stall", 32'(stall[0]), 32'd0);
    chk("abort_done",  32'(done[0]), 32'd0);
    chk("abort_rdata", rdata[0], 32'd0);
    step();
    step();
    rst_n[0] = 1'b1;
    step();
    do_ld(0, F3_W, 32'h8, 32'h11223344, "lw_8_after_abort");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory responder for the core's load/store path. It accepts the MEM_RD/MEM_WR strobes and operand signals produced for load (0000011) and store (0100011) instructions. It services each request against an internal word-organised RAM with a programmable wait-state count, and stalls the core until the access completes. It returns sign- or zero-extended load data for the writeback mux.

Parameters:
ADDR_W, 10, word-address bits; RAM depth = 2**ADDR_W words of 32 bits.
WAIT_CYCLES, 2, extra busy cycles per access; range 0..15.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
mem_rd  in  1  load request; held by the core while stall=1.
mem_wr  in  1  store request; held by the core while stall=1.
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
addr  in  32  byte address (ALU result).
wdata  in  32  store data (rs2), right-aligned.
rdata  out  32  extended load data; valid when done=1.
stall  out  1  freeze PC/pipeline while high.
done  out  1  one-cycle completion pulse.
err  out  1  one-cycle pulse with done on an illegal access.

Behaviour:
- Reset (async, rst_n=0): state IDLE, rdata=0, done=0, err=0, stall=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stall=0.
- IDLE, request (mem_rd|mem_wr): stall=1 combinationally in the same cycle. addr, funct3, wdata and direction are latched at the clock edge.
  - Illegal request: goes to RESP with err flagged. No RAM access.
  - Legal request: goes to BUSY with counter=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
- Illegal conditions:
  - mem_rd&mem_wr both high.
  - funct3 not in the legal set for the direction (stores: 000/001/010 only).
  - Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- BUSY: stall=1; the counter decrements each cycle. When counter=1, the edge performs the access and moves to RESP.
  - Store: byte-enabled RAM write. Only the selected lanes change.
  - Load: RAM word captured.
- RESP (exactly one cycle):
  - stall=0, done=1, err as flagged.
  - rdata = extracted lane: B/H sign-extended, BU/HU zero-extended, W unchanged. rdata=0 on error.
  - Inputs are ignored in this cycle; the next state is IDLE.
  - rdata holds its value until the next RESP.
- Timing: stall is high for WAIT_CYCLES+1 cycles. done is asserted WAIT_CYCLES+1 cycles after the accepting edge.
  - Back-to-back memory instructions: the next request is accepted in the IDLE cycle following RESP.
- Address: word index = addr[ADDR_W+1:2]. Higher bits are ignored, so accesses wrap modulo RAM size.
- Byte lanes: SB writes wdata[7:0] to lane addr[1:0]. SH writes wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1.
- Reset mid-operation (in BUSY): the access is aborted. A store not yet committed leaves RAM unchanged. No done pulse.
- done and err never assert outside RESP. err=1 implies done=1.

Decomposition:
- Shared package:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Opcode constants OP_LOAD and OP_STORE.
  - FSM state encoding.
- One natural sub-module: dmem_ram. Synchronous single-port 32-bit RAM with a 4-bit byte-enable write and registered read.
- The controller holds the FSM, the alignment/legality check, lane steering and load extension.

Test Plan:
- WAIT_CYCLES=2; SW wdata=0xDEADBEEF addr=0x10, then LW addr=0x10.
  -> stall high 3 cycles per access; done at cycle 3 after accept; rdata=0xDEADBEEF, err=0.
- SW 0x00000000 @0x4; SB 0x000000F0 @0x5.
  -> LW @0x4 = 0x0000F000; LB @0x5 = 0xFFFFFFF0; LBU @0x5 = 0x000000F0.
- SH 0x00008001 @0x22.
  -> LH @0x22 = 0xFFFF8001; LHU @0x22 = 0x00008001; LW @0x20 = 0x80010000 if that word was zeroed first.
- LW addr=0x6, then SH addr=0x3 with wdata=0x1234.
  -> each gives done=1, err=1, rdata=0; RAM at 0x0/0x4 unchanged.
- mem_rd=mem_wr=1 -> err pulse.
  Then WAIT_CYCLES=0 run: LW accepted -> done on next cycle, stall high 1 cycle.
  Address 0x10 + 4*2**ADDR_W aliases to 0x10.
- SW 0x55AA55AA @0x8 with rst_n pulsed low during the BUSY cycle before commit.
  -> outputs immediately 0, no done; subsequent LW @0x8 returns the prior value.
